uart_cpu_bridge: RTL
====================

# uart_cpu_bridge

UART command/response bridge between the host link and the BIP-I CPU core. It decodes single-byte commands from the UART receiver: run-to-halt, single-step, or read-only. It gates the CPU with a clock enable, captures the CPU result word, and returns it to the host as a framed byte stream through the UART transmitter. It is the parametrised successor of the fixed 16-bit run-and-report controller: the result width is configurable, and it adds a step mode, a run timeout, a status byte and a busy flag.

## Interface
Parameters:
- DATA_W, 16: result width in bits; multiple of 8, at least 8. NBYTES = DATA_W/8.
- MAX_CYCLES, 1024: run timeout in enabled CPU cycles; at least 2.
- CMD_RUN, 8'h01: run-to-halt command.
- CMD_STEP, 8'h02: single-step command.
- CMD_READ, 8'h03: read-result-only command.
- ST_OK, 8'hA5: status byte for normal completion.
- ST_TMO, 8'h5A: status byte when a run times out.

Ports:
- i_clk, in, 1: system clock.
- i_reset, in, 1: synchronous, active-high reset.
- i_rx_data, in, 8: received byte; valid when i_rx_done is high.
- i_rx_done, in, 1: one-cycle pulse, byte received.
- i_tx_done, in, 1: one-cycle pulse, transmitter finished the current byte.
- o_tx_data, out, 8: byte to transmit; registered.
- o_tx_start, out, 1: one-cycle transmit request.
- o_cpu_en, out, 1: CPU clock enable.
- i_cpu_halt, in, 1: CPU halted (level).
- i_cpu_result, in, DATA_W: CPU result word.
- o_busy, out, 1: high in every state except IDLE.

## Operation
- States: IDLE, RUN, STEP, LOAD, TX_START, TX_WAIT.
- IDLE: sampled only when i_rx_done=1.
  - CMD_RUN -> RUN, run counter cleared.
  - CMD_STEP -> STEP.
  - CMD_READ -> LOAD, status ST_OK.
  - Any other byte is ignored; the state stays IDLE.
- RUN: o_cpu_en=1.
  - i_cpu_halt=1 -> LOAD with ST_OK.
  - Otherwise, counter == MAX_CYCLES-1 -> LOAD with ST_TMO.
  - Otherwise the counter increments.
  - Halt has priority over timeout in the same cycle.
  - If halt is already high on entry, RUN lasts exactly one cycle and reports ST_OK.
- STEP: o_cpu_en=1 for exactly one cycle -> LOAD with ST_OK.
- LOAD: shift register <= i_cpu_result; o_tx_data <= status; byte index <= 0 -> TX_START.
- TX_START: o_tx_start=1 -> TX_WAIT.
- TX_WAIT: waits for i_tx_done.
  - On i_tx_done with index == NBYTES -> IDLE.
  - Otherwise: o_tx_data <= shift[DATA_W-1:DATA_W-8], shift <<= 8, index++ -> TX_START.
- Frame format: status byte, then NBYTES result bytes, MSB first, NBYTES+1 bytes in total.
- i_rx_done is ignored outside IDLE. Bytes are not queued.
- i_tx_done is ignored outside TX_WAIT, including a pulse in the same cycle as o_tx_start.
- o_cpu_en is 0 in IDLE, LOAD, TX_START and TX_WAIT, so the result stays stable during capture and transmit.
- Width rules:
  - Run counter width: $clog2(MAX_CYCLES).
  - Byte index width: $clog2(NBYTES+1).
  - Neither wraps; both are cleared on entry to their state.

## Timing
- Reset values:
  - State IDLE.
  - o_tx_start=0, o_tx_data=8'h00, o_cpu_en=0, o_busy=0.
  - Counter, index and shift register all zero.
- o_cpu_en, o_tx_start and o_busy are decoded from the registered state: no combinational path from the inputs.
- Latencies, with command accepted at the cycle-0 edge:
  - RUN/STEP: o_cpu_en high from cycle 1.
  - STEP: enable high cycle 1 only; LOAD cycle 2; first o_tx_start cycle 3.
  - READ: LOAD cycle 1; o_tx_start cycle 2.
  - Halt seen in RUN at cycle k: LOAD at k+1, o_tx_start at k+2.
  - Timeout: o_cpu_en is high for exactly MAX_CYCLES cycles.
- Transmit handshake:
  - o_tx_data is stable from the o_tx_start cycle until the i_tx_done that ends that byte.
  - The next o_tx_start comes exactly one cycle after each i_tx_done.
  - Successive starts are never closer than 2 cycles apart.
- Reset mid-operation: within one cycle, the block aborts RUN or a frame in progress.
  - No further o_tx_start.
  - o_cpu_en drops.
  - Pending i_tx_done is ignored.

## Test plan
- READ, DATA_W=16: i_cpu_result=16'hBEEF, rx 8'h03 -> tx bytes A5, BE, EF in order, one start per i_tx_done; o_cpu_en never high; o_busy low afterwards.
- RUN to halt: rx 8'h01, halt asserted after 37 enabled cycles, result 16'h0123 -> o_cpu_en high exactly 37 cycles, then frame A5, 01, 23.
- RUN timeout: MAX_CYCLES=8, halt tied low, rx 8'h01 -> o_cpu_en high exactly 8 cycles, then frame 5A plus the current result.
- STEP plus width: DATA_W=32, result 32'h11223344, rx 8'h02 -> o_cpu_en high exactly 1 cycle; frame A5, 11, 22, 33, 44.
- Ignored input: unknown byte 8'h7F in IDLE -> no activity. rx 8'h03 mid-frame -> frame unchanged and no second frame.
- Reset mid-frame: i_reset after the 2nd tx byte -> no further o_tx_start, all outputs at reset values next cycle; a following READ yields a complete fresh frame.

Source files
------------

// File: rtl/uart_cpu_bridge_if.sv
// rtl/uart_cpu_bridge_if.sv - UART and CPU signal bundle for uart_cpu_bridge
interface uart_cpu_bridge_if #(
    parameter int DATA_W = 16
);
    logic [7:0]        i_rx_data;
    logic              i_rx_done;
    logic              i_tx_done;
    logic [7:0]        o_tx_data;
    logic              o_tx_start;
    logic              o_cpu_en;
    logic              i_cpu_halt;
    logic [DATA_W-1:0] i_cpu_result;
    logic              o_busy;

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_cpu_halt, i_cpu_result,
        input  o_tx_data, o_tx_start, o_cpu_en, o_busy
    );

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_cpu_halt, i_cpu_result,
        output o_tx_data, o_tx_start, o_cpu_en, o_busy
    );
endinterface

// File: rtl/uart_cpu_bridge.sv
// rtl/uart_cpu_bridge.sv - UART command decoder, CPU run/step gate and framed result sender
module uart_cpu_bridge #(
    parameter int          DATA_W     = 16,
    parameter int          MAX_CYCLES = 1024,
    parameter logic [7:0]  CMD_RUN    = 8'h01,
    parameter logic [7:0]  CMD_STEP   = 8'h02,
    parameter logic [7:0]  CMD_READ   = 8'h03,
    parameter logic [7:0]  ST_OK      = 8'hA5,
    parameter logic [7:0]  ST_TMO     = 8'h5A
) (
    input  logic                i_clk,
    input  logic                i_reset,
    uart_cpu_bridge_if.slave    bus
);
    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_CYCLES);
    localparam int IDX_W  = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_STEP, S_LOAD, S_TX_START, S_TX_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  run_cnt;
    logic [IDX_W-1:0]  byte_idx;
    logic [DATA_W-1:0] shift_q;
    logic [7:0]        status_q;
    logic [7:0]        tx_data_q;

    logic run_timeout;
    logic last_byte;
    assign run_timeout = (run_cnt == CNT_W'(MAX_CYCLES - 1));
    assign last_byte   = (byte_idx == IDX_W'(NBYTES));

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.i_rx_done) begin
                    if (bus.i_rx_data == CMD_RUN)       state_nxt = S_RUN;
                    else if (bus.i_rx_data == CMD_STEP) state_nxt = S_STEP;
                    else if (bus.i_rx_data == CMD_READ) state_nxt = S_LOAD;
                end
            end
            S_RUN:      if (bus.i_cpu_halt || run_timeout) state_nxt = S_LOAD;
            S_STEP:     state_nxt = S_LOAD;
            S_LOAD:     state_nxt = S_TX_START;
            S_TX_START: state_nxt = S_TX_WAIT;
            S_TX_WAIT:  if (bus.i_tx_done) state_nxt = last_byte ? S_IDLE : S_TX_START;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Enables are pure state decodes so no input can reach them combinationally.
    always_comb begin
        bus.o_cpu_en   = (state == S_RUN) || (state == S_STEP);
        bus.o_tx_start = (state == S_TX_START);
        bus.o_busy     = (state != S_IDLE);
        bus.o_tx_data  = tx_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            run_cnt   <= '0;
            byte_idx  <= '0;
            shift_q   <= '0;
            status_q  <= 8'h00;
            tx_data_q <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_rx_done) begin
                        if (bus.i_rx_data == CMD_RUN) run_cnt <= '0;
                        status_q <= ST_OK;
                    end
                end
                S_RUN: begin
                    // Halt wins over timeout when both land in the same cycle.
                    if (bus.i_cpu_halt)    status_q <= ST_OK;
                    else if (run_timeout)  status_q <= ST_TMO;
                    else                   run_cnt  <= run_cnt + CNT_W'(1);
                end
                S_STEP: status_q <= ST_OK;
                S_LOAD: begin
                    shift_q   <= bus.i_cpu_result;
                    tx_data_q <= status_q;
                    byte_idx  <= '0;
                end
                S_TX_WAIT: begin
                    if (bus.i_tx_done && !last_byte) begin
                        tx_data_q <= shift_q[DATA_W-1 -: 8];
                        shift_q   <= shift_q << 8;
                        byte_idx  <= byte_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
